// File: rtl/score_accumulator_bcd.sv
`default_nettype none
// ============================================================================
// Module   : score_accumulator_bcd
// Purpose  : Signed score accumulator for the game datapath. Number-hit pulses
//            add or subtract the hit object's value according to the current
//            operand mode. The result is clamped to +/-MAX_SCORE, and an
//            iterative shift-add-3 engine converts |score| to BCD digits for
//            the VGA number drawers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   system clock
//   resetN          in   synchronous active-low reset
//   SingleHitPulse  in   [NUMBERS]     one-cycle hit pulse per number object
//   operandHit      in   [2]           bit0 plus-operand hit, bit1 minus-operand hit
//   NumbersToShow   in   [NUMBERS][4]  value carried by each number object
//   clearScore      in   synchronous score clear (new round)
//   ScoreToShow     out  [DIGITS][4]   BCD digits, index 0 = most significant
//   SignToShow      out  displayed score is negative
//   ShowSign        out  displayed score is non-zero
//   scoreValid      out  display registers match the accumulator
//   overflowFlag    out  sticky, set when an update saturated
// ----------------------------------------------------------------------------
// Build option
//   SCORE_LEADING_BLANK_EN : when defined, leading zero digits (all but the
//                            least significant) are driven as 4'hF so the
//                            drawers render them blank.
// ============================================================================
module score_accumulator_bcd #(
    parameter int NUMBERS   = 3,
    parameter int DIGITS    = 3,
    parameter int MAG_W     = 10,
    parameter int MAX_SCORE = 999
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NUMBERS-1:0]        SingleHitPulse,
    input  logic [1:0]                operandHit,
    input  logic [NUMBERS-1:0][3:0]   NumbersToShow,
    input  logic                      clearScore,
    output logic [DIGITS-1:0][3:0]    ScoreToShow,
    output logic                      SignToShow,
    output logic                      ShowSign,
    output logic                      scoreValid,
    output logic                      overflowFlag
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_SUM_W = MAG_W + 2;          // headroom for score +/- 15
    localparam int c_CNT_W = $clog2(MAG_W + 1);
    localparam int c_BCD_W = DIGITS * 4;

    localparam logic signed [c_SUM_W-1:0] c_MAX_POS = c_SUM_W'(MAX_SCORE);
    localparam logic signed [c_SUM_W-1:0] c_MAX_NEG = -c_MAX_POS;
    localparam logic [c_CNT_W-1:0]        c_LAST    = c_CNT_W'(MAG_W - 1);

    // ------------------------------------------------------------------------
    // State encodings
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLUS  = 2'd1,
        MINUS = 2'd2
    } op_state_t;

    typedef enum logic [1:0] {
        CIDLE = 2'd0,
        CONV  = 2'd1,
        CDONE = 2'd2
    } cv_state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    op_state_t                  r_op_state;
    op_state_t                  w_op_next;
    logic signed [MAG_W:0]      r_score;
    logic signed [MAG_W:0]      w_score_next;
    logic                       w_ovf_next;
    logic                       r_chg;          // score register changed last edge

    logic                       w_hit_any;
    logic [3:0]                 w_hit_val;
    logic signed [c_SUM_W-1:0]  w_score_ext;
    logic signed [c_SUM_W-1:0]  w_delta;
    logic signed [c_SUM_W-1:0]  w_sum;

    cv_state_t                  r_cv_state;
    logic                       r_pending;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [MAG_W-1:0]           r_bin;
    logic [c_BCD_W-1:0]         r_bcd;
    logic                       r_neg;
    logic                       r_nonzero;
    logic [MAG_W:0]             w_abs;
    logic [c_BCD_W-2:0]         w_bcd_adj;
    logic [DIGITS-1:0][3:0]     w_digits;
`ifdef SCORE_LEADING_BLANK_EN
    logic                       w_lead;
`endif

    // ------------------------------------------------------------------------
    // Hit selection: the lowest asserted index wins. The loop walks downward
    // so the last assignment made is the lowest index.
    // ------------------------------------------------------------------------
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_val = 4'd0;
        for (int i = NUMBERS - 1; i >= 0; i--) begin
            if (SingleHitPulse[i]) begin
                w_hit_any = 1'b1;
                w_hit_val = NumbersToShow[i];
            end
        end
    end

    assign w_score_ext = {r_score[MAG_W], r_score};
    assign w_delta     = {{(c_SUM_W - 4){1'b0}}, w_hit_val};
    // The hit uses the mode held before this edge, so an operand hit in the
    // same cycle only affects later hits.
    assign w_sum       = (r_op_state == MINUS) ? (w_score_ext - w_delta)
                                               : (w_score_ext + w_delta);

    // ------------------------------------------------------------------------
    // Next-state for the accumulator and the operand mode
    // ------------------------------------------------------------------------
    always_comb begin
        w_op_next    = r_op_state;
        w_score_next = r_score;
        w_ovf_next   = overflowFlag;
        if (clearScore) begin
            // A clear beats both a hit and an operand hit in the same cycle.
            w_op_next    = IDLE;
            w_score_next = '0;
            w_ovf_next   = 1'b0;
        end else begin
            if (operandHit[0]) begin
                w_op_next = PLUS;
            end else if (operandHit[1]) begin
                w_op_next = MINUS;
            end
            if ((r_op_state != IDLE) && w_hit_any) begin
                if (w_sum > c_MAX_POS) begin
                    w_score_next = c_MAX_POS[MAG_W:0];
                    w_ovf_next   = 1'b1;
                end else if (w_sum < c_MAX_NEG) begin
                    w_score_next = c_MAX_NEG[MAG_W:0];
                    w_ovf_next   = 1'b1;
                end else begin
                    w_score_next = w_sum[MAG_W:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_op_state   <= IDLE;
            r_score      <= '0;
            overflowFlag <= 1'b0;
            r_chg        <= 1'b0;
        end else begin
            r_op_state   <= w_op_next;
            r_score      <= w_score_next;
            overflowFlag <= w_ovf_next;
            r_chg        <= (w_score_next != r_score);
        end
    end

    // ------------------------------------------------------------------------
    // Binary-to-BCD (double dabble), one bit per cycle
    // ------------------------------------------------------------------------
    assign w_abs = r_score[MAG_W] ? -r_score : r_score;

    // Add 3 to every digit >= 5 before the shift. The top digit's MSB would
    // shift out of the register, so only its low three bits are kept. The
    // value is below 10^DIGITS, so that bit is always zero.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dd_adj
        if (g < DIGITS - 1) begin : g_full
            assign w_bcd_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ?
                                         (r_bcd[g*4 +: 4] + 4'd3) : r_bcd[g*4 +: 4];
        end else begin : g_top
            assign w_bcd_adj[g*4 +: 3] = 3'((r_bcd[g*4 +: 4] >= 4'd5) ?
                                            (r_bcd[g*4 +: 4] + 4'd3) : r_bcd[g*4 +: 4]);
        end
    end

    // Digit ordering for the drawers: index 0 is the most significant digit.
    always_comb begin
        w_digits = '0;
`ifdef SCORE_LEADING_BLANK_EN
        w_lead   = 1'b1;
`endif
        for (int d = 0; d < DIGITS; d++) begin
            w_digits[d] = r_bcd[(DIGITS - 1 - d)*4 +: 4];
`ifdef SCORE_LEADING_BLANK_EN
            // The least significant digit is always shown so that 0 stays visible.
            if ((d < DIGITS - 1) && w_lead && (w_digits[d] == 4'd0)) begin
                w_digits[d] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Converter control. The display registers change only when a conversion
    // finishes with no newer score waiting. A result superseded by a change
    // during conversion is dropped, so a stale intermediate value never
    // reaches the drawers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_cv_state  <= CIDLE;
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_neg       <= 1'b0;
            r_nonzero   <= 1'b0;
            ScoreToShow <= '0;
            SignToShow  <= 1'b0;
            ShowSign    <= 1'b0;
            scoreValid  <= 1'b1;
        end else begin
            case (r_cv_state)
                CIDLE: begin
                    if (r_chg) begin
                        r_bin      <= w_abs[MAG_W-1:0];
                        r_neg      <= r_score[MAG_W];
                        r_nonzero  <= |w_abs;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        scoreValid <= 1'b0;
                        r_cv_state <= CONV;
                    end
                end

                CONV: begin
                    if (r_chg) begin
                        r_pending <= 1'b1;
                    end
                    r_bcd <= {w_bcd_adj, r_bin[MAG_W-1]};
                    r_bin <= {r_bin[MAG_W-2:0], 1'b0};
                    if (r_cnt == c_LAST) begin
                        r_cv_state <= CDONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                CDONE: begin
                    // A change arriving in this very cycle counts as pending too.
                    if (r_pending || r_chg) begin
                        r_pending  <= 1'b0;
                        r_bin      <= w_abs[MAG_W-1:0];
                        r_neg      <= r_score[MAG_W];
                        r_nonzero  <= |w_abs;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        scoreValid <= 1'b0;
                        r_cv_state <= CONV;
                    end else begin
                        ScoreToShow <= w_digits;
                        SignToShow  <= r_neg;
                        ShowSign    <= r_nonzero;
                        scoreValid  <= 1'b1;
                        r_cv_state  <= CIDLE;
                    end
                end

                default: begin
                    r_cv_state <= CIDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_accumulator_bcd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_score_accumulator_bcd
// Purpose  : Self-checking bench for score_accumulator_bcd. A behavioural
//            score model predicts the display. Predictions are queued when
//            stimulus is driven and are popped when scoreValid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_accumulator_bcd;

    localparam int NUMBERS   = 3;
    localparam int DIGITS    = 3;
    localparam int MAG_W     = 10;
    localparam int MAX_SCORE = 999;
    localparam int c_LAT     = 1 + 1 + MAG_W + 1;

    typedef logic [DIGITS-1:0][3:0] disp_t;
    typedef struct packed {
        disp_t digits;
        logic  sign;
        logic  show;
    } exp_t;

    logic                    clk;
    logic                    resetN;
    logic [NUMBERS-1:0]      SingleHitPulse;
    logic [1:0]              operandHit;
    logic [NUMBERS-1:0][3:0] NumbersToShow;
    logic                    clearScore;
    disp_t                   ScoreToShow;
    logic                    SignToShow;
    logic                    ShowSign;
    logic                    scoreValid;
    logic                    overflowFlag;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   m_score;
    int   m_mode;      // 0 idle, 1 plus, 2 minus
    bit   m_ovf;

    score_accumulator_bcd #(
        .NUMBERS  (NUMBERS),
        .DIGITS   (DIGITS),
        .MAG_W    (MAG_W),
        .MAX_SCORE(MAX_SCORE)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .SingleHitPulse(SingleHitPulse),
        .operandHit    (operandHit),
        .NumbersToShow (NumbersToShow),
        .clearScore    (clearScore),
        .ScoreToShow   (ScoreToShow),
        .SignToShow    (SignToShow),
        .ShowSign      (ShowSign),
        .scoreValid    (scoreValid),
        .overflowFlag  (overflowFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected digit pattern for a magnitude, index 0 = most significant.
    function automatic disp_t exp_digits(input int mag);
        disp_t r;
        int    div;
`ifdef SCORE_LEADING_BLANK_EN
        bit    lead;
        lead = 1'b1;
`endif
        r   = '0;
        div = 1;
        for (int k = 1; k < DIGITS; k++) div = div * 10;
        for (int d = 0; d < DIGITS; d++) begin
            r[d] = 4'((mag / div) % 10);
`ifdef SCORE_LEADING_BLANK_EN
            if ((d < DIGITS - 1) && lead && (r[d] == 4'd0)) r[d] = 4'hF;
            else lead = 1'b0;
`endif
            div = div / 10;
        end
        return r;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.digits = exp_digits((m_score < 0) ? -m_score : m_score);
        e.sign   = (m_score < 0);
        e.show   = (m_score != 0);
        return e;
    endfunction

    task automatic expect_now();
        q.push_back(model_exp());
    endtask

    // Drive one cycle of stimulus and step the model with the pre-edge mode.
    task automatic drive(input logic [NUMBERS-1:0] hits, input logic [1:0] ops,
                         input logic clr);
        int val;
        int s;
        bit found;
        found = 1'b0;
        val   = 0;
        for (int i = 0; i < NUMBERS; i++) begin
            if (hits[i] && !found) begin
                found = 1'b1;
                val   = int'(NumbersToShow[i]);
            end
        end
        if (clr) begin
            m_score = 0;
            m_ovf   = 1'b0;
            m_mode  = 0;
        end else begin
            if (found && (m_mode != 0)) begin
                s = (m_mode == 1) ? (m_score + val) : (m_score - val);
                if (s > MAX_SCORE) begin
                    s = MAX_SCORE;
                    m_ovf = 1'b1;
                end else if (s < -MAX_SCORE) begin
                    s = -MAX_SCORE;
                    m_ovf = 1'b1;
                end
                m_score = s;
            end
            if (ops[0]) m_mode = 1;
            else if (ops[1]) m_mode = 2;
        end
        SingleHitPulse = hits;
        operandHit     = ops;
        clearScore     = clr;
        @(posedge clk);
        #1;
        SingleHitPulse = '0;
        operandHit     = 2'b00;
        clearScore     = 1'b0;
    endtask

    // Wait (bounded) for scoreValid to drop and then rise again. lat counts
    // edges since the edge that sampled the hit. glitches counts invalid
    // cycles in which the display moved away from its value at entry.
    task automatic wait_done(input int lat0, output int lat, output bit timeout,
                             output int glitches);
        disp_t held;
        bit    seen_low;
        held     = ScoreToShow;
        seen_low = (scoreValid === 1'b0);
        lat      = lat0;
        timeout  = 1'b0;
        glitches = 0;
        while (!(seen_low && (scoreValid === 1'b1))) begin
            if (lat > lat0 + 400) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
            if (scoreValid === 1'b0) begin
                seen_low = 1'b1;
                if (ScoreToShow !== held) glitches++;
            end
        end
    endtask

    task automatic test_reset();
        resetN         = 1'b0;
        SingleHitPulse = '0;
        operandHit     = 2'b00;
        NumbersToShow  = '0;
        clearScore     = 1'b0;
        m_score = 0; m_mode = 0; m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ScoreToShow !== disp_t'(0)) begin
            n_fail++; $display("FAIL reset_digits: got %h expected 000", ScoreToShow);
        end
        n_checks++;
        if ({SignToShow, ShowSign} !== 2'b00) begin
            n_fail++; $display("FAIL reset_sign: got %b%b expected 00", SignToShow, ShowSign);
        end
        n_checks++;
        if (scoreValid !== 1'b1) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 1", scoreValid);
        end
        n_checks++;
        if (overflowFlag !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflowFlag);
        end
    endtask

    task automatic test_plus();
        int lat; bit to; int gl; exp_t e;
        NumbersToShow[1] = 4'd7;
        drive('0, 2'b01, 1'b0);
        drive(3'b010, 2'b00, 1'b0);
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || (lat != c_LAT)) begin
            n_fail++; $display("FAIL plus_latency: got %0d (timeout %0d) expected %0d", lat, to, c_LAT);
        end
        n_checks++;
        if ({ScoreToShow, SignToShow, ShowSign} !== e) begin
            n_fail++; $display("FAIL plus_display: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
    endtask

    task automatic test_minus();
        int lat; bit to; int gl; exp_t e;
        drive('0, 2'b10, 1'b0);
        NumbersToShow[1] = 4'd9;
        drive(3'b010, 2'b00, 1'b0);            // 7 - 9 = -2
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL minus_neg: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
        drive('0, 2'b01, 1'b0);
        NumbersToShow[1] = 4'd2;
        drive(3'b010, 2'b00, 1'b0);            // -2 + 2 = 0
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL minus_zero: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
    endtask

    task automatic test_saturate_clear();
        int lat; bit to; int gl; exp_t e; int lows;
        NumbersToShow[0] = 4'd15;
        repeat (66) drive(3'b001, 2'b00, 1'b0);  // 990
        NumbersToShow[0] = 4'd5;
        drive(3'b001, 2'b00, 1'b0);              // 995
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL sat_995: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
        n_checks++;
        if (overflowFlag !== m_ovf) begin
            n_fail++; $display("FAIL sat_noflag: got %b expected %b", overflowFlag, m_ovf);
        end
        NumbersToShow[0] = 4'd9;
        drive(3'b001, 2'b00, 1'b0);              // clamps to 999
        n_checks++;
        if (overflowFlag !== 1'b1) begin
            n_fail++; $display("FAIL sat_flag: got %b expected 1", overflowFlag);
        end
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL sat_999: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
        drive('0, 2'b00, 1'b1);
        n_checks++;
        if (overflowFlag !== 1'b0) begin
            n_fail++; $display("FAIL clear_flag: got %b expected 0", overflowFlag);
        end
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL clear_display: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
        // The mode is IDLE now, so this hit must not start a conversion.
        NumbersToShow[0] = 4'd5;
        drive(3'b001, 2'b00, 1'b0);
        lows = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (scoreValid !== 1'b1) lows++;
        end
        n_checks++;
        if ((lows != 0) || (ScoreToShow !== exp_digits(0))) begin
            n_fail++; $display("FAIL idle_ignore: got invalid cycles %0d digits %h expected 0 / %h",
                               lows, ScoreToShow, exp_digits(0));
        end
    endtask

    task automatic test_priority();
        int lat; bit to; int gl; exp_t e;
        NumbersToShow[0] = 4'd3;
        NumbersToShow[1] = 4'd0;
        NumbersToShow[2] = 4'd5;
        drive('0, 2'b01, 1'b0);
        drive(3'b101, 2'b00, 1'b0);             // only index 0: +3
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL prio_lowest: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
        drive(3'b001, 2'b10, 1'b0);             // old mode PLUS: 3 + 3
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL prio_oldmode: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
        drive(3'b100, 2'b00, 1'b0);             // now MINUS: 6 - 5
        expect_now();
        wait_done(1, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || ({ScoreToShow, SignToShow, ShowSign} !== e)) begin
            n_fail++; $display("FAIL prio_newmode: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit to; int gl; exp_t e;
        drive('0, 2'b01, 1'b0);
        NumbersToShow[0] = 4'd4;
        NumbersToShow[2] = 4'd6;
        drive(3'b001, 2'b00, 1'b0);             // 1 + 4
        repeat (3) drive('0, 2'b00, 1'b0);
        drive(3'b100, 2'b00, 1'b0);             // + 6, mid-conversion
        expect_now();
        // The restart follows the first CDONE, so the second result lands
        // one full conversion after edge c_LAT.
        wait_done(5, lat, to, gl);
        e = q.pop_front();
        n_checks++;
        if (to || (lat != c_LAT + MAG_W + 1)) begin
            n_fail++; $display("FAIL b2b_latency: got %0d (timeout %0d) expected %0d",
                               lat, to, c_LAT + MAG_W + 1);
        end
        n_checks++;
        if (gl != 0) begin
            n_fail++; $display("FAIL b2b_glitch: got %0d display changes expected 0", gl);
        end
        n_checks++;
        if ({ScoreToShow, SignToShow, ShowSign} !== e) begin
            n_fail++; $display("FAIL b2b_display: got %h/%b/%b expected %h/%b/%b",
                               ScoreToShow, SignToShow, ShowSign, e.digits, e.sign, e.show);
        end
    endtask

    task automatic test_reset_mid_conv();
        int lows;
        NumbersToShow[0] = 4'd4;
        drive(3'b001, 2'b00, 1'b0);             // mode still PLUS
        repeat (4) drive('0, 2'b00, 1'b0);      // converter is in CONV now
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        m_score = 0; m_mode = 0; m_ovf = 1'b0;
        q.delete();
        n_checks++;
        if ({ScoreToShow, SignToShow, ShowSign, scoreValid, overflowFlag} !==
            {disp_t'(0), 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL midreset_outputs: got %h/%b/%b/%b/%b expected 000/0/0/1/0",
                               ScoreToShow, SignToShow, ShowSign, scoreValid, overflowFlag);
        end
        drive(3'b001, 2'b00, 1'b0);             // IDLE after reset: ignored
        lows = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (scoreValid !== 1'b1) lows++;
        end
        n_checks++;
        if ((lows != 0) || (ScoreToShow !== disp_t'(0))) begin
            n_fail++; $display("FAIL midreset_idle: got invalid cycles %0d digits %h expected 0 / 000",
                               lows, ScoreToShow);
        end
    endtask

    initial begin
        test_reset();
        test_plus();
        test_minus();
        test_saturate_clear();
        test_priority();
        test_back_to_back();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
